fifo_sync_stat: RTL and testbench

Parametrised single-clock FIFO that succeeds the fixed 33-bit × 2048 buffer used for event/trigger data. It generalises width and depth and fixes full detection, so all 2^AW words are usable. It adds a bus-programmable nearly-full threshold and sticky overflow/underflow flags, a dropped-write counter and a high-water mark, all readable on the register-file bus. It sits between the trigger/event pipelines and the readout bus.

---
 rtl/fifo_stat_pkg.sv | 30 +++
 rtl/fifo_stat_ram.sv | 36 +++
 rtl/fifo_sync_stat.sv | 212 +++++++++++++++++++++
 tb/tb_fifo_sync_stat.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stat_pkg.sv
// fifo_stat_pkg: shared constants for the fifo_sync_stat block.
//   - register-bus field layout (34-bit request bus, 16-bit read-data bus)
//   - register offsets relative to BASEADDR
//   - bit positions inside the status register
package fifo_stat_pkg;

    // Request bus: {clk, wr, addr[15:0], wrdata[15:0]}
    localparam int IBUS_W        = 34;
    localparam int OBUS_W        = 16;
    localparam int IBUS_CLK_BIT  = 33;
    localparam int IBUS_WR_BIT   = 32;
    localparam int IBUS_ADDR_LSB = 16;
    localparam int IBUS_DATA_LSB = 0;

    // Register offsets from BASEADDR
    typedef enum logic [1:0] {
        REG_THR  = 2'd0,   // RW nearly-full threshold
        REG_STAT = 2'd1,   // RO status, any write clears sticky state
        REG_DROP = 2'd2,   // RO dropped-write counter
        REG_HWM  = 2'd3    // RO high-water mark
    } reg_off_e;

    // Status register bit positions
    localparam int ST_NEMPTY = 0;
    localparam int ST_NFULL  = 1;
    localparam int ST_FULL   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_UNF    = 4;

endpackage

// File: rtl/fifo_stat_ram.sv
// fifo_stat_ram: simple dual-port RAM, W x 2^AW, one write port and one
// registered read port, both on clk.
//   clk   : clock
//   we    : write enable;  waddr / wdata : write address / data
//   re    : read enable;   raddr         : read address
//   rdata : registered read data, holds its value while re is low
// A read and a write to the same address on the same edge return the old
// word (read-first); the FIFO relies on this when full with wen and ren.
module fifo_stat_ram #(
    parameter int W  = 33,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_reg [2**AW];
    logic [W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/fifo_sync_stat.sv
// fifo_sync_stat: single-clock FIFO (W x 2^AW) with register-bus statistics.
//   clk, rst   : clock, synchronous active-high reset (registered once)
//   ibus       : register bus request {clk, wr, addr[15:0], wrdata[15:0]}
//   obus       : register read data at BASEADDR..BASEADDR+3, high-Z elsewhere
//   d, wen     : write data / write request
//   ren, q     : read request / registered read data (1-cycle latency)
//   nempty     : at least one word stored
//   full       : 2^AW words stored
//   nwords     : occupancy, zero-extended to 16 bits
//   nearlyfull : registered (thr != 0) && (nwords >= thr)
module fifo_sync_stat
    import fifo_stat_pkg::*;
#(
    parameter int          W        = 33,
    parameter int          AW       = 11,
    parameter logic [15:0] BASEADDR = 16'h0000,
    parameter int          AFULL_PU = (1 << AW) - 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IBUS_W-1:0] ibus,
    output logic [OBUS_W-1:0] obus,
    input  logic [W-1:0]      d,
    input  logic              wen,
    input  logic              ren,
    output logic [W-1:0]      q,
    output logic              nempty,
    output logic              full,
    output logic [15:0]       nwords,
    output logic              nearlyfull
);

    // ---------------------------------------------------------------
    // Reset pipeline and pointers
    // ---------------------------------------------------------------
    logic          rst_q_reg;
    logic          rst_any;
    logic [AW:0]   wptr_reg;
    logic [AW:0]   rptr_reg;
    logic [AW:0]   occ;

    always_ff @(posedge clk) begin
        rst_q_reg <= rst;
    end

    assign rst_any = rst | rst_q_reg;

    // One extra pointer bit distinguishes full from empty, so every
    // RAM location is usable.
    assign occ    = wptr_reg - rptr_reg;
    assign nwords = 16'(occ);
    assign nempty = (occ != '0);
    assign full   = (occ == {1'b1, {AW{1'b0}}});

    // ---------------------------------------------------------------
    // Transfer qualification
    // ---------------------------------------------------------------
    logic do_wr;
    logic do_rd;
    logic drop_ev;
    logic unf_ev;

    // When full, a simultaneous read frees the slot being written.
    assign do_wr   = wen && !rst_any && (!full || ren);
    assign drop_ev = wen && !rst_any && full && !ren;
    // No fall-through: a read on an empty FIFO underflows even if a
    // write lands on the same edge.
    assign do_rd   = ren && !rst_any && nempty;
    assign unf_ev  = ren && !rst_any && !nempty;

    // ---------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------
    logic [W-1:0] ram_q;
    logic         q_zero_reg;

    fifo_stat_ram #(
        .W  (W),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wptr_reg[AW-1:0]),
        .wdata (d),
        .re    (do_rd),
        .raddr (rptr_reg[AW-1:0]),
        .rdata (ram_q)
    );

    // The RAM output register cannot be reset, so reset and underflow
    // force q to zero through a mask flag instead.
    assign q = q_zero_reg ? '0 : ram_q;

    // ---------------------------------------------------------------
    // Register bus decode
    // ---------------------------------------------------------------
    logic        bus_wr;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] addr_off;
    logic        in_block;
    reg_off_e    reg_sel;
    logic        wr_thr;
    logic        clr_stat;
    logic        unused_bus_clk;

    assign bus_wr         = ibus[IBUS_WR_BIT];
    assign bus_addr       = ibus[IBUS_ADDR_LSB +: 16];
    assign bus_wdata      = ibus[IBUS_DATA_LSB +: 16];
    // The bus clock bit is the same net as clk.
    assign unused_bus_clk = ibus[IBUS_CLK_BIT];

    // Offset arithmetic wraps modulo 2^16, so the block may sit anywhere.
    assign addr_off = bus_addr - BASEADDR;
    assign in_block = (addr_off[15:2] == '0);
    assign reg_sel  = reg_off_e'(addr_off[1:0]);
    assign wr_thr   = bus_wr && in_block && (reg_sel == REG_THR);
    assign clr_stat = bus_wr && in_block && (reg_sel == REG_STAT);

    // ---------------------------------------------------------------
    // Control and statistics registers
    // ---------------------------------------------------------------
    logic [15:0] thr_reg;
    logic        nearlyfull_reg;
    logic        ovf_reg;
    logic        unf_reg;
    logic [15:0] drop_reg;
    logic [15:0] hwm_reg;

    always_ff @(posedge clk) begin
        if (rst_q_reg) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            q_zero_reg     <= 1'b1;
            nearlyfull_reg <= 1'b0;
            ovf_reg        <= 1'b0;
            unf_reg        <= 1'b0;
            drop_reg       <= '0;
            hwm_reg        <= '0;
            thr_reg        <= 16'(AFULL_PU);
        end else begin
            if (do_wr) begin
                wptr_reg <= wptr_reg + (AW+1)'(1);
            end
            if (do_rd) begin
                rptr_reg   <= rptr_reg + (AW+1)'(1);
                q_zero_reg <= 1'b0;
            end else if (unf_ev) begin
                q_zero_reg <= 1'b1;
            end

            nearlyfull_reg <= (thr_reg != '0) && (nwords >= thr_reg);

            if (wr_thr) begin
                thr_reg <= bus_wdata;
            end

            // A same-cycle event beats the clear, so nothing is lost.
            if (clr_stat) begin
                ovf_reg  <= drop_ev;
                unf_reg  <= unf_ev;
                drop_reg <= drop_ev ? 16'd1 : 16'd0;
                hwm_reg  <= nwords;
            end else begin
                if (drop_ev) begin
                    ovf_reg <= 1'b1;
                    if (drop_reg != 16'hFFFF) begin
                        drop_reg <= drop_reg + 16'd1;
                    end
                end
                if (unf_ev) begin
                    unf_reg <= 1'b1;
                end
                if (nwords > hwm_reg) begin
                    hwm_reg <= nwords;
                end
            end
        end
    end

    assign nearlyfull = nearlyfull_reg;

    // ---------------------------------------------------------------
    // Bus read mux
    // ---------------------------------------------------------------
    logic [15:0] stat_word;
    logic [15:0] rd_word;

    always_comb begin
        stat_word            = '0;
        stat_word[ST_NEMPTY] = nempty;
        stat_word[ST_NFULL]  = nearlyfull_reg;
        stat_word[ST_FULL]   = full;
        stat_word[ST_OVF]    = ovf_reg;
        stat_word[ST_UNF]    = unf_reg;
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_THR:  rd_word = thr_reg;
            REG_STAT: rd_word = stat_word;
            REG_DROP: rd_word = drop_reg;
            REG_HWM:  rd_word = hwm_reg;
            default:  rd_word = '0;
        endcase
    end

    // Shared bus: only drive while our own addresses are selected.
    assign obus = in_block ? rd_word : 16'bz;

endmodule

// File: tb/tb_fifo_sync_stat.sv
// tb_fifo_sync_stat: directed bench for fifo_sync_stat (W=33, AW=4).
// Stimulus pushes the expected q of every read request into a scoreboard
// queue; a monitor pops and compares q the cycle after each request.
// Flags, occupancy and bus registers are compared against hand values.
module tb_fifo_sync_stat;

    localparam int          W     = 33;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [15:0] BASE  = 16'h0040;
    localparam int          AFP   = 13;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          bwr   = 1'b0;
    logic [15:0]   baddr = '0;
    logic [15:0]   bdata = '0;
    logic [33:0]   ibus;
    wire  [15:0]   obus;
    logic [W-1:0]  d     = '0;
    logic          wen   = 1'b0;
    logic          ren   = 1'b0;
    logic [W-1:0]  q;
    logic          nempty;
    logic          full;
    logic [15:0]   nwords;
    logic          nearlyfull;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] model[$];   // words the FIFO should hold, oldest first
    logic [W-1:0] exp_q[$];   // expected q for each outstanding read

    always #5 clk = ~clk;

    assign ibus = {clk, bwr, baddr, bdata};

    fifo_sync_stat #(
        .W        (W),
        .AW       (AW),
        .BASEADDR (BASE),
        .AFULL_PU (AFP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ibus       (ibus),
        .obus       (obus),
        .d          (d),
        .wen        (wen),
        .ren        (ren),
        .q          (q),
        .nempty     (nempty),
        .full       (full),
        .nwords     (nwords),
        .nearlyfull (nearlyfull)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // One FIFO cycle; inputs change #1 after the edge.
    task automatic cyc(input logic w, input logic [W-1:0] dv, input logic r);
        bit was_full;
        bit was_empty;
        was_full  = (model.size() == DEPTH);
        was_empty = (model.size() == 0);
        wen = w;
        d   = dv;
        ren = r;
        if (r) begin
            if (was_empty) exp_q.push_back('0);
            else           exp_q.push_back(model.pop_front());
        end
        if (w && (!was_full || r)) model.push_back(dv);
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
        baddr = a;
        bdata = v;
        bwr   = 1'b1;
        @(posedge clk);
        #1;
        bwr   = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
        baddr = a;
        bwr   = 1'b0;
        #1;
        v = obus;
    endtask

    // Scoreboard monitor: q is presented one edge after a read request.
    initial begin
        logic         rd_taken;
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            rd_taken = ren;
            #2;
            if (rd_taken) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL q_sb: read seen with no expected value, q=%0h", q);
                end else begin
                    e = exp_q.pop_front();
                    check("q", 64'(q), 64'(e));
                end
            end
        end
    end

    initial begin
        logic [15:0] v;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_nwords", 64'(nwords), 64'd0);
        check("rst_nempty", 64'(nempty), 64'd0);
        check("rst_full",   64'(full),   64'd0);
        check("rst_q",      64'(q),      64'd0);
        bus_read(BASE + 16'd1, v); check("rst_stat", 64'(v), 64'd0);
        bus_read(BASE + 16'd0, v); check("rst_thr",  64'(v), 64'(AFP));
        bus_read(BASE + 16'd2, v); check("rst_drop", 64'(v), 64'd0);
        bus_read(BASE + 16'd3, v); check("rst_hwm",  64'(v), 64'd0);

        // ---------------- 1: fill, overflow, drain ----------------
        for (int i = 0; i < 16; i++) cyc(1'b1, 33'h1_0000_0000 + 33'(i), 1'b0);
        check("t1_full",   64'(full),   64'd1);
        check("t1_nwords", 64'(nwords), 64'd16);
        cyc(1'b1, 33'h0_0000_BEEF, 1'b0);
        // nempty, nearlyfull (16 >= 13), full, ovf
        bus_read(BASE + 16'd1, v); check("t1_stat", 64'(v), 64'h000F);
        bus_read(BASE + 16'd2, v); check("t1_drop", 64'(v), 64'd1);
        check("t1_nwords_ovf", 64'(nwords), 64'd16);
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);
        check("t1_nempty", 64'(nempty), 64'd0);
        check("t1_nwords_end", 64'(nwords), 64'd0);

        // ---------------- 2: underflow, status clear ----------------
        cyc(1'b0, '0, 1'b1);
        check("t2_nwords", 64'(nwords), 64'd0);
        bus_read(BASE + 16'd1, v); check("t2_stat", 64'(v), 64'h0018);
        bus_write(BASE + 16'd1, 16'hFFFF);
        bus_read(BASE + 16'd1, v); check("t2_stat_clr", 64'(v), 64'd0);
        bus_read(BASE + 16'd2, v); check("t2_drop_clr", 64'(v), 64'd0);

        // ---------------- 3: nearly-full threshold ----------------
        bus_write(BASE + 16'd0, 16'd12);
        bus_read(BASE + 16'd0, v); check("t3_thr", 64'(v), 64'd12);
        for (int i = 0; i < 12; i++) cyc(1'b1, 33'h0_0000_0100 + 33'(i), 1'b0);
        check("t3_nwords12", 64'(nwords), 64'd12);
        check("t3_nf_lag", 64'(nearlyfull), 64'd0);
        cyc(1'b0, '0, 1'b0);
        check("t3_nf_rise", 64'(nearlyfull), 64'd1);
        cyc(1'b0, '0, 1'b1);
        check("t3_nwords11", 64'(nwords), 64'd11);
        check("t3_nf_hold", 64'(nearlyfull), 64'd1);
        cyc(1'b0, '0, 1'b0);
        check("t3_nf_fall", 64'(nearlyfull), 64'd0);
        bus_write(BASE + 16'd0, 16'd0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 33'h0_0000_0200 + 33'(i), 1'b0);
        check("t3_full", 64'(full), 64'd1);
        cyc(1'b0, '0, 1'b0);
        check("t3_nf_disabled", 64'(nearlyfull), 64'd0);

        // ---------------- 4: full with wen+ren across wrap ----------------
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 33'h1_5500_0000 + 33'(i), 1'b1);
            check("t4_nwords", 64'(nwords), 64'd16);
        end
        bus_read(BASE + 16'd2, v); check("t4_drop", 64'(v), 64'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);
        check("t4_empty", 64'(nempty), 64'd0);

        // ---------------- 5: high-water mark ----------------
        bus_write(BASE + 16'd1, 16'd0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 33'h0_0000_0900 + 33'(i), 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 33'h0_0000_0A00 + 33'(i), 1'b0);
        bus_read(BASE + 16'd3, v); check("t5_hwm9", 64'(v), 64'd9);
        bus_write(BASE + 16'd1, 16'd0);
        bus_read(BASE + 16'd3, v); check("t5_hwm3", 64'(v), 64'd3);

        // ---------------- 6: reset mid-operation, foreign address ----------------
        for (int i = 0; i < 4; i++) cyc(1'b1, 33'h0_0000_0B00 + 33'(i), 1'b0);
        check("t6_nwords7", 64'(nwords), 64'd7);
        rst = 1'b1;
        wen = 1'b1;
        d   = 33'h0_0BAD_0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wen = 1'b0;
        model.delete();
        @(posedge clk);
        #1;
        check("t6_nwords_rst", 64'(nwords), 64'd0);
        check("t6_q_rst", 64'(q), 64'd0);
        bus_read(BASE + 16'd0, v); check("t6_thr_rst", 64'(v), 64'(AFP));
        @(posedge clk);
        #1;
        check("t6_no_wr_in_rst", 64'(nempty), 64'd0);
        bus_read(BASE + 16'd3, v); check("t6_hwm_rst", 64'(v), 64'd0);
        cyc(1'b1, 33'h1_2345_6789, 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        // A two-state simulator resolves an undriven bus to 0.
        bus_read(BASE + 16'd4, v);
        check("t6_obus_above", 64'((v === 16'hzzzz || v === 16'h0000) ? 1 : 0), 64'd1);
        bus_read(BASE - 16'd1, v);
        check("t6_obus_below", 64'((v === 16'hzzzz || v === 16'h0000) ? 1 : 0), 64'd1);

        repeat (2) @(posedge clk);
        #3;
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
